// File: rtl/param_reg_bank.sv
// param_reg_bank
//   Bank of NUM_REGS independent WIDTH-bit function registers used as the
//   general-purpose / address register block. All enabled registers apply
//   the same operation (fun_sel) in parallel on each rising clock edge.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset (registers <- RESET_VAL, carry <- 0)
//   fun_sel   in   3-bit operation: hold/clear/load/dec/inc/shl/shr/rotl
//   reg_en    in   NUM_REGS bitmask, bit i enables the operation on register i
//   data_in   in   WIDTH load data shared by all enabled registers
//   rd_sel_a  in   read port A select
//   rd_sel_b  in   read port B select
//   out_a     out  register[rd_sel_a], 0 when rd_sel_a >= NUM_REGS
//   out_b     out  register[rd_sel_b], 0 when rd_sel_b >= NUM_REGS
//   zero_a    out  out_a == 0
//   carry     out  registered carry / borrow / shift-out of the lowest enabled register
module param_reg_bank #(
    parameter int                 WIDTH     = 8,
    parameter int                 NUM_REGS  = 4,
    parameter int                 SAT       = 0,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    parameter int                 SELW      = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            fun_sel,
    input  logic [NUM_REGS-1:0]   reg_en,
    input  logic [WIDTH-1:0]      data_in,
    input  logic [SELW-1:0]       rd_sel_a,
    input  logic [SELW-1:0]       rd_sel_b,
    output logic [WIDTH-1:0]      out_a,
    output logic [WIDTH-1:0]      out_b,
    output logic                  zero_a,
    output logic                  carry
);

    localparam logic [2:0] F_HOLD = 3'b000;
    localparam logic [2:0] F_CLR  = 3'b001;
    localparam logic [2:0] F_LOAD = 3'b010;
    localparam logic [2:0] F_DEC  = 3'b011;
    localparam logic [2:0] F_INC  = 3'b100;
    localparam logic [2:0] F_SHL  = 3'b101;
    localparam logic [2:0] F_SHR  = 3'b110;
    localparam logic [2:0] F_ROTL = 3'b111;

    localparam int RD_DEPTH = 1 << SELW;

    logic [WIDTH-1:0] regs_q [NUM_REGS];
    logic [WIDTH-1:0] regs_d [NUM_REGS];
    logic             carry_q;
    logic             carry_d;
    logic [WIDTH-1:0] rd_arr [RD_DEPTH];

    // Increment, optionally clamped at all-ones.
    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        if (SAT != 0 && v == '1)
            return v;
        return v + WIDTH'(1);
    endfunction

    // Decrement, optionally clamped at zero.
    function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
        if (SAT != 0 && v == '0)
            return v;
        return v - WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] next_val(input logic [WIDTH-1:0] v,
                                                  input logic [2:0]       f,
                                                  input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        r = v;
        case (f)
            F_HOLD: r = v;
            F_CLR:  r = '0;
            F_LOAD: r = d;
            F_DEC:  r = sat_dec(v);
            F_INC:  r = sat_inc(v);
            F_SHL:  r = {v[WIDTH-2:0], 1'b0};
            F_SHR:  r = {1'b0, v[WIDTH-1:1]};
            F_ROTL: r = {v[WIDTH-2:0], v[WIDTH-1]};
            default: r = v;
        endcase
        return r;
    endfunction

    // Carry reflects the wrap condition even when saturation clamps the value.
    function automatic logic carry_of(input logic [WIDTH-1:0] v,
                                      input logic [2:0]       f);
        logic c;
        c = 1'b0;
        case (f)
            F_DEC:         c = (v == '0);
            F_INC:         c = (v == '1);
            F_SHL, F_ROTL: c = v[WIDTH-1];
            F_SHR:         c = v[0];
            default:       c = 1'b0;
        endcase
        return c;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (reg_en[i])
                regs_d[i] = next_val(regs_q[i], fun_sel, data_in);
        end
    end

    // Only the lowest-index enabled register drives the carry flag.
    always_comb begin
        logic found;
        found   = 1'b0;
        carry_d = carry_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_en[i] && !found) begin
                found = 1'b1;
                if (fun_sel != F_HOLD)
                    carry_d = carry_of(regs_q[i], fun_sel);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= RESET_VAL;
            carry_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= regs_d[i];
            carry_q <= carry_d;
        end
    end

    // Pad the read space to a power of two so out-of-range selects read 0.
    for (genvar g = 0; g < RD_DEPTH; g++) begin : g_rd
        if (g < NUM_REGS) begin : g_live
            assign rd_arr[g] = regs_q[g];
        end else begin : g_pad
            assign rd_arr[g] = '0;
        end
    end

    assign out_a  = rd_arr[rd_sel_a];
    assign out_b  = rd_arr[rd_sel_b];
    assign zero_a = (out_a == '0);
    assign carry  = carry_q;

endmodule

// File: doc/param_reg_bank.md
Name:
param_reg_bank

Overview:
- Parametrised bank of NUM_REGS independent WIDTH-bit function registers.
- Each register performs clear / load / decrement / increment / shift / rotate under a shared function select, gated per register by a bitmask enable.
- Two combinational read ports and a registered carry flag.
- Serves as the general-purpose / address register block feeding the datapath ALU and memory address logic.

Parameters:
- WIDTH, 8: bits per register (>=2).
- NUM_REGS, 4: number of registers (>=2).
- SAT, 0: 0 = inc/dec wrap modulo 2^WIDTH; 1 = inc/dec saturate at all-ones / zero.
- RESET_VAL, 0: value every register takes on reset (WIDTH bits).
- SELW, $clog2(NUM_REGS): read-select width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- fun_sel  in  3  operation code (see Behaviour).
- reg_en  in  NUM_REGS  bitmask; bit i enables the operation on register i.
- data_in  in  WIDTH  load data, shared by all enabled registers.
- rd_sel_a  in  SELW  read port A select.
- rd_sel_b  in  SELW  read port B select.
- out_a  out  WIDTH  contents of register rd_sel_a.
- out_b  out  WIDTH  contents of register rd_sel_b.
- zero_a  out  1  high when out_a == 0 (combinational).
- carry  out  1  registered carry / borrow / shift-out flag.

Behaviour:
- Reset (rst_n low, async, takes effect immediately and regardless of clk): all registers = RESET_VAL, carry = 0. out_a/out_b reflect RESET_VAL as soon as reset asserts. Reset asserted mid-operation discards that cycle's update. First update occurs on the first rising edge after rst_n goes high.
- fun_sel encoding, applied on a rising edge to every register i with reg_en[i] = 1:
  - 000 hold
  - 001 clear (0)
  - 010 load data_in
  - 011 decrement
  - 100 increment
  - 101 shift left (LSB <- 0)
  - 110 logical shift right (MSB <- 0)
  - 111 rotate left (LSB <- old MSB)
- Registers with reg_en[i] = 0 hold. reg_en = 0 or fun_sel = 000: no register changes, carry unchanged.
- Write latency 1 cycle: new value visible on out_a/out_b after the edge.
- Read latency 0: out_a/out_b/zero_a are combinational on current register state and rd_sel.
- rd_sel >= NUM_REGS (non-power-of-two NUM_REGS): output 0, zero_a = 1.
- Arithmetic is WIDTH-bit unsigned.
  - SAT = 0: inc of all-ones -> 0; dec of 0 -> all-ones.
  - SAT = 1: inc of all-ones stays all-ones; dec of 0 stays 0.
- Carry source: the lowest-index register with reg_en set. Other enabled registers update normally but do not affect carry. Carry updates only when reg_en != 0 and fun_sel != 000:
  - clear / load: carry = 0.
  - inc: carry = 1 iff old value is all-ones (in either SAT mode), else 0.
  - dec: carry = 1 iff old value is 0 (borrow), else 0.
  - shl / rotl: carry = old MSB.
  - shr: carry = old LSB.
- Simultaneous read and write of the same register in one cycle: the read returns the pre-edge value; the new value appears after the edge. There is no bypass.
- No undefined states: all fun_sel codes are defined, and all registers are updated in parallel in a single clock.

Test Plan:
- Reset: WIDTH=8, NUM_REGS=4, RESET_VAL=8'h5A. Assert rst_n low between edges -> out_a = out_b = 8'h5A immediately, carry = 0. Release rst_n, then issue inc on reg_en=4'b0001 -> R0 = 8'h5B one edge later.
- Wrap (SAT=0): load 8'hFF into R1 (reg_en=0010), then inc -> R1 = 8'h00, carry = 1. Then dec -> R1 = 8'hFF, carry = 1. Then dec -> 8'hFE, carry = 0.
- Saturate (SAT=1): R2 = 8'hFF, inc -> stays 8'hFF, carry = 1. R2 = 8'h00, dec -> stays 8'h00, carry = 1, zero_a = 1 with rd_sel_a = 2.
- Multi-register + carry source: reg_en=4'b1010, load 8'h81, then shl -> R1 = R3 = 8'h02, carry = 1 (from R1). Then shr -> R1 = R3 = 8'h01, carry = 0. Then rotl on R3 = 8'h80 -> 8'h01, carry = 1.
- Hold/disable: fun_sel=000 with reg_en=1111, or fun_sel=100 with reg_en=0000 -> all registers and carry unchanged for 3 cycles.
- Read-during-write + async reset mid-op: rd_sel_a = 0 while inc R0 from 8'h10 -> out_a = 8'h10 before the edge, 8'h11 after. Pulse rst_n low between edges -> R0 = RESET_VAL immediately, no pending update applied.
